clock_display_scanner: RTL and testbench

Consumes the six BCD digits produced by the seconds, minutes and hours counters (HH:MM:SS) and drives a time-multiplexed, common-anode 6-digit 7-segment display. It latches a coherent snapshot of the digits once per scan frame so a counter tick mid-frame cannot tear the display. It applies ghost-suppression blanking and leading-zero blanking, and flashes the field currently being edited. It sits between the clock counter chain and the board display pins.

---
 rtl/clock_display_scanner.sv | 139 +++++++++++++
 tb/tb_clock_display_scanner.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/clock_display_scanner.sv
// Time-multiplexed scanner for a common-anode 6-digit HH:MM:SS display.
// Takes a tear-free snapshot each frame and applies ghost, leading-zero and edit-blink blanking.
module clock_display_scanner #(
  parameter logic [15:0] REFRESH_DIV = 16'd50000,
  parameter logic [15:0] BLANK_CYC   = 16'd500,
  parameter logic [7:0]  BLINK_DIV   = 8'd60,
  parameter bit          HOUR_LZB    = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] HMSD,
  input  logic [3:0] HLSD,
  input  logic [3:0] MMSD,
  input  logic [3:0] MLSD,
  input  logic [3:0] SMSD,
  input  logic [3:0] SLSD,
  input  logic       EditEnable,
  input  logic [1:0] EditSel,
  output logic [5:0] AN,
  output logic [6:0] SEG,
  output logic       DP
);

  localparam int CNT_W = (REFRESH_DIV > 16'd1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FRM_W = (BLINK_DIV > 8'd1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 16'd1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_DIV - 8'd1);

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [FRM_W-1:0] r_frm;
  logic             r_phase;
  logic [5:0][3:0]  r_snap;
  logic [5:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  logic             w_cntLast;
  logic             w_idxLast;
  logic             w_frameEnd;
  logic             w_inBlank;
  logic             w_fieldHit;
  logic             w_segBlank;
  logic [3:0]       w_digit;
  logic [6:0]       w_pattern;
  logic [5:0]       w_an;
  logic [6:0]       w_seg;
  logic             w_dp;

  assign w_cntLast  = (r_cnt == CNT_LAST);
  assign w_idxLast  = (r_idx == 3'd5);
  assign w_frameEnd = w_cntLast && w_idxLast;
  assign w_inBlank  = (r_cnt < BLANK_END);

  // Slot pairs (0/1, 2/3, 4/5) map onto edit fields 1, 2, 3; EditSel 0 never matches.
  assign w_fieldHit = EditEnable && (EditSel != 2'd0) && (EditSel == (r_idx[2:1] + 2'd1));

  assign w_segBlank = w_inBlank
                   || (HOUR_LZB && w_idxLast && (r_snap[5] == 4'h0))
                   || (w_fieldHit && !r_phase);

  always_comb begin
    w_digit = 4'h0;
    case (r_idx)
      3'd0: w_digit = r_snap[0];
      3'd1: w_digit = r_snap[1];
      3'd2: w_digit = r_snap[2];
      3'd3: w_digit = r_snap[3];
      3'd4: w_digit = r_snap[4];
      3'd5: w_digit = r_snap[5];
      default: w_digit = 4'h0;
    endcase
  end

  always_comb begin
    w_pattern = 7'b0111111;
    case (w_digit)
      4'd0: w_pattern = 7'b1000000;
      4'd1: w_pattern = 7'b1111001;
      4'd2: w_pattern = 7'b0100100;
      4'd3: w_pattern = 7'b0110000;
      4'd4: w_pattern = 7'b0011001;
      4'd5: w_pattern = 7'b0010010;
      4'd6: w_pattern = 7'b0000010;
      4'd7: w_pattern = 7'b1111000;
      4'd8: w_pattern = 7'b0000000;
      4'd9: w_pattern = 7'b0010000;
      default: w_pattern = 7'b0111111;
    endcase
  end

  assign w_an  = w_inBlank ? 6'b111111 : ~(6'd1 << r_idx);
  assign w_seg = w_segBlank ? 7'b1111111 : w_pattern;
  assign w_dp  = !(((r_idx == 3'd2) || (r_idx == 3'd4)) && !w_inBlank && r_phase);

  // Scan position and per-frame snapshot/blink bookkeeping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_frm   <= '0;
      r_phase <= 1'b1;
      r_snap  <= '0;
    end else begin
      r_cnt <= w_cntLast ? '0 : r_cnt + CNT_W'(1);
      if (w_cntLast) begin
        r_idx <= w_idxLast ? 3'd0 : r_idx + 3'd1;
      end
      if (w_frameEnd) begin
        r_snap <= {HMSD, HLSD, MMSD, MLSD, SMSD, SLSD};
        if (r_frm == FRM_LAST) begin
          r_frm   <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_frm <= r_frm + FRM_W'(1);
        end
      end
    end
  end

  // Registered pin drivers so the board sees glitch-free anode/segment lines.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_an  <= 6'b111111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign AN  = r_an;
  assign SEG = r_seg;
  assign DP  = r_dp;

endmodule

// File: tb/tb_clock_display_scanner.sv
// Scoreboard bench for clock_display_scanner with a small scan (4-cycle slots, 2-frame blink).
// Each frame's expected lit cycles are queued at frame start; a negedge monitor pops and compares.
module tb_clock_display_scanner;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [13:0] RESET_OUT = {6'b111111, 7'b1111111, 1'b1};

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] HMSD, HLSD, MMSD, MLSD, SMSD, SLSD;
  logic       EditEnable;
  logic [1:0] EditSel;
  logic [5:0] AN;
  logic [6:0] SEG;
  logic       DP;

  int          checks = 0;
  int          errors = 0;
  int          edgeCount = 0;
  bit          monOn = 1'b0;
  logic [13:0] expQ[$];

  clock_display_scanner #(
    .REFRESH_DIV(16'd4),
    .BLANK_CYC(16'd1),
    .BLINK_DIV(8'd2),
    .HOUR_LZB(1'b1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .HMSD(HMSD),
    .HLSD(HLSD),
    .MMSD(MMSD),
    .MLSD(MLSD),
    .SMSD(SMSD),
    .SLSD(SLSD),
    .EditEnable(EditEnable),
    .EditSel(EditSel),
    .AN(AN),
    .SEG(SEG),
    .DP(DP)
  );

  always #5 CLK = ~CLK;

  // Edges since reset release; frame f starts after edge 24*f.
  always @(posedge CLK or posedge RST) begin
    if (RST) edgeCount <= 0;
    else     edgeCount <= edgeCount + 1;
  end

  task automatic checkOutput(input string name, input logic [13:0] act, input logic [13:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got AN=%b SEG=%b DP=%b, required AN=%b SEG=%b DP=%b",
               name, act[13:8], act[7:1], act[0], req[13:8], req[7:1], req[0]);
    end
  endtask

  task automatic checkDrained(input string name);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s: %0d expected slot cycles left unseen, required 0", name, expQ.size());
    end
  endtask

  task automatic waitEdge(input int target);
    int n = 0;
    while (edgeCount != target && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    if (edgeCount != target) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitEdge: edge count %0d, required %0d", edgeCount, target);
    end
  endtask

  // At the start of frame f: drive the live edit controls and queue the frame's lit cycles.
  // segs is {slot5..slot0}; each slot has three lit cycles after its single blank cycle.
  task automatic applyStimulus(input int f, input logic en, input logic [1:0] sel,
                               input logic [41:0] segs, input logic ph, input int nEntries);
    int n = 0;
    waitEdge(24 * f + 1);
    EditEnable = en;
    EditSel    = sel;
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < 3; c++) begin
        if (n < nEntries) begin
          expQ.push_back({~(6'd1 << s), segs[7*s +: 7], (ph && (s == 2 || s == 4)) ? 1'b0 : 1'b1});
          n++;
        end
      end
    end
  endtask

  // Monitor: blank cycles must be fully dark; lit cycles consume the scoreboard in order.
  always @(negedge CLK) begin
    if (monOn) begin
      if (AN === 6'b111111) begin
        checkOutput($sformatf("blankCycle e%0d", edgeCount), {AN, SEG, DP}, RESET_OUT);
      end else if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL underflow e%0d: got AN=%b SEG=%b with nothing expected", edgeCount, AN, SEG);
      end else begin
        checkOutput($sformatf("slot e%0d", edgeCount), {AN, SEG, DP}, expQ.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RST = 1'b0;
    {HMSD, HLSD, MMSD, MLSD, SMSD, SLSD} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    EditEnable = 1'b0;
    EditSel    = 2'd0;
    #1 RST = 1'b1;
    #1 checkOutput("resetAsync", {AN, SEG, DP}, RESET_OUT);
    repeat (3) @(negedge CLK);
    checkOutput("resetHeld", {AN, SEG, DP}, RESET_OUT);
    RST   = 1'b0;
    monOn = 1'b1;

    applyStimulus(0, 1'b0, 2'd0, {SB, S0, S0, S0, S0, S0}, 1'b1, 18);
    applyStimulus(1, 1'b0, 2'd0, {S1, S2, S3, S4, S5, S6}, 1'b1, 18);
    SLSD = 4'd7;
    applyStimulus(2, 1'b0, 2'd0, {S1, S2, S3, S4, S5, S7}, 1'b0, 18);
    SLSD = 4'hC;
    HMSD = 4'd0;
    applyStimulus(3, 1'b1, 2'd2, {SB, S2, SB, SB, S5, SD}, 1'b0, 18);
    SLSD = 4'd9;
    HMSD = 4'd1;
    applyStimulus(4, 1'b1, 2'd2, {S1, S2, S3, S4, S5, S9}, 1'b1, 18);
    applyStimulus(5, 1'b1, 2'd3, {S1, S2, S3, S4, S5, S9}, 1'b1, 18);
    applyStimulus(6, 1'b1, 2'd3, {SB, SB, S3, S4, S5, S9}, 1'b0, 18);
    applyStimulus(7, 1'b1, 2'd1, {S1, S2, S3, S4, SB, SB}, 1'b0, 18);
    applyStimulus(8, 1'b0, 2'd2, {S1, S2, S3, S4, S5, S9}, 1'b1, 18);
    MMSD = 4'd8;
    HLSD = 4'd0;
    applyStimulus(9, 1'b0, 2'd2, {S1, S0, S8, S4, S5, S9}, 1'b1, 18);
    applyStimulus(10, 1'b1, 2'd0, {S1, S0, S8, S4, S5, S9}, 1'b0, 18);
    applyStimulus(11, 1'b1, 2'd2, {S1, S0, SB, SB, S5, S9}, 1'b0, 10);

    // Scan is now at slot 3, count 2: reset must clear the pins before the next edge.
    waitEdge(24 * 11 + 14);
    #2;
    monOn = 1'b0;
    RST   = 1'b1;
    #1 checkOutput("resetMidScan", {AN, SEG, DP}, RESET_OUT);
    checkDrained("preResetDrain");
    EditEnable = 1'b0;
    EditSel    = 2'd0;
    repeat (3) @(negedge CLK);
    checkOutput("resetMidHeld", {AN, SEG, DP}, RESET_OUT);
    RST   = 1'b0;
    monOn = 1'b1;

    applyStimulus(0, 1'b0, 2'd0, {SB, S0, S0, S0, S0, S0}, 1'b1, 18);
    applyStimulus(1, 1'b0, 2'd0, {S1, S0, S8, S4, S5, S9}, 1'b1, 18);
    waitEdge(24 * 2 + 1);
    monOn = 1'b0;
    checkDrained("finalDrain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
